// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: round-robin between ALU and
// load writeback, plus a pending-write scoreboard for read-after-write stalls.
module rf_write_arbiter (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        alu_req,
  input  logic [4:0]  alu_index,
  input  logic [31:0] alu_data,
  output logic        alu_grant,
  input  logic        mem_req,
  input  logic [4:0]  mem_index,
  input  logic [31:0] mem_data,
  output logic        mem_grant,
  input  logic        issue_valid,
  input  logic [4:0]  issue_index,
  input  logic [4:0]  query_index1,
  input  logic [4:0]  query_index2,
  output logic        busy1,
  output logic        busy2,
  output logic        stall,
  output logic        rf_write,
  output logic [4:0]  rf_write_index,
  output logic [31:0] rf_write_data,
  output logic [5:0]  pending_count
);

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } last_t;

  last_t       last, last_next;
  logic [31:0] pending, pending_next;
  logic [5:0]  count_next;
  logic        xfer;
  logic [4:0]  xfer_index;
  logic [31:0] xfer_data;
  logic        set_hit, clr_hit, set_new, clr_eff;

  // On a tie the source that did not win last time goes first.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (clear_n) begin
      if (alu_req && (!mem_req || last == LAST_MEM))
        alu_grant = 1'b1;
      else if (mem_req)
        mem_grant = 1'b1;
    end
  end

  always_comb begin
    xfer       = alu_grant | mem_grant;
    xfer_index = alu_grant ? alu_index : mem_index;
    xfer_data  = alu_grant ? alu_data  : mem_data;
    last_next  = last;
    if (alu_grant) last_next = LAST_ALU;
    if (mem_grant) last_next = LAST_MEM;
  end

  // Set is applied after clear so a same-index issue keeps the bit alive;
  // the count only moves when a bit actually changes.
  always_comb begin
    set_hit = issue_valid && (issue_index != '0);
    clr_hit = xfer && (xfer_index != '0);
    set_new = set_hit && !pending[issue_index];
    clr_eff = clr_hit && pending[xfer_index] &&
              !(set_hit && (issue_index == xfer_index));

    pending_next = pending;
    if (clr_hit) pending_next[xfer_index]  = 1'b0;
    if (set_hit) pending_next[issue_index] = 1'b1;
    pending_next[0] = 1'b0;

    count_next = pending_count;
    case ({set_new, clr_eff})
      2'b10:   count_next = pending_count + 6'd1;
      2'b01:   count_next = pending_count - 6'd1;
      default: count_next = pending_count;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      last           <= LAST_MEM;
      pending        <= '0;
      pending_count  <= '0;
      rf_write       <= 1'b0;
      rf_write_index <= '0;
      rf_write_data  <= '0;
    end else begin
      last          <= last_next;
      pending       <= pending_next;
      pending_count <= count_next;
      rf_write      <= clr_hit;
      if (xfer) begin
        rf_write_index <= xfer_index;
        rf_write_data  <= xfer_data;
      end
    end
  end

  always_comb begin
    busy1 = pending[query_index1];
    busy2 = pending[query_index2];
    stall = busy1 | busy2;
  end

endmodule
